// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and helpers for the ALU command sequencer.
package alu_pkg;

    localparam int NREG = 4;
    localparam int W    = 4;

    localparam logic [3:0] OP_XFER = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_SUB1 = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_DEC  = 4'h6;
    localparam logic [3:0] OP_DECX = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOT  = 4'hB;
    localparam logic [3:0] OP_LOAD = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake, ALU drive/capture and debug read port of the sequencer.
interface alu_cmd_sequencer_if;
    import alu_pkg::*;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [1:0]   cmd_dst;
    logic [1:0]   cmd_src_a;
    logic [1:0]   cmd_src_b;
    logic [W-1:0] cmd_imm;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         rsp_err;

    logic [W-1:0] alu_x;
    logic [W-1:0] alu_y;
    logic [3:0]   alu_select;
    logic [W-1:0] alu_out;
    logic         alu_c_out;

    logic [1:0]   dbg_addr;
    logic [W-1:0] dbg_data;

    // Host plus external ALU side
    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        output rsp_ready, alu_out, alu_c_out, dbg_addr,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err,
        input  alu_x, alu_y, alu_select, dbg_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        input  rsp_ready, alu_out, alu_c_out, dbg_addr,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err,
        output alu_x, alu_y, alu_select, dbg_data
    );

endinterface

// File: rtl/alu_regfile.sv
// 4 x 4-bit register file: one synchronous write port, three combinational read ports.
module alu_regfile
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_we,
    input  logic [1:0]   i_waddr,
    input  logic [W-1:0] i_wdata,
    input  logic [1:0]   i_raddr_a,
    input  logic [1:0]   i_raddr_b,
    input  logic [1:0]   i_raddr_d,
    output logic [W-1:0] o_rdata_a,
    output logic [W-1:0] o_rdata_b,
    output logic [W-1:0] o_rdata_d
);

    logic [W-1:0] w_regs [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [W-1:0] r_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_q <= '0;
                end else if (i_we && (i_waddr == 2'(gi))) begin
                    r_q <= i_wdata;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    assign o_rdata_a = w_regs[i_raddr_a];
    assign o_rdata_b = w_regs[i_raddr_b];
    assign o_rdata_d = w_regs[i_raddr_d];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts one register-file command at a time, runs it on the external ALU, writes back and responds.
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    alu_cmd_sequencer_if.slave  bus
);

    state_t       r_state;
    state_t       w_state_next;
    logic         w_cmd_ready;

    logic [3:0]   r_op;
    logic [1:0]   r_dst;
    logic [W-1:0] r_imm;
    logic [W-1:0] r_alu_x;
    logic [W-1:0] r_alu_y;
    logic [3:0]   r_alu_sel;
    logic         r_carry;
    logic         r_zero;

    logic         r_rsp_valid;
    logic [W-1:0] r_rsp_data;
    logic         r_rsp_carry;
    logic         r_rsp_zero;
    logic         r_rsp_err;

    logic [W-1:0] w_rd_a;
    logic [W-1:0] w_rd_b;
    logic         w_alu_op;
    logic         w_load;
    logic         w_we;
    logic [W-1:0] w_result;
    logic         w_new_carry;
    logic         w_new_zero;

    alu_regfile u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_we      (w_we),
        .i_waddr   (r_dst),
        .i_wdata   (w_result),
        .i_raddr_a (bus.cmd_src_a),
        .i_raddr_b (bus.cmd_src_b),
        .i_raddr_d (bus.dbg_addr),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b),
        .o_rdata_d (bus.dbg_data)
    );

    // ALU outputs only matter in EXEC; every write and flag update is gated by it
    assign w_alu_op    = (r_op <= OP_NOT);
    assign w_load      = (r_op == OP_LOAD);
    assign w_we        = (r_state == EXEC) && (w_alu_op || w_load);
    assign w_result    = w_load ? r_imm : bus.alu_out;
    assign w_new_carry = (w_alu_op && is_arith(r_op)) ? bus.alu_c_out : r_carry;
    assign w_new_zero  = (w_alu_op || w_load) ? (w_result == '0) : r_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) w_state_next = EXEC;
            end
            EXEC: w_state_next = RESP;
            RESP: if (bus.rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= '0;
            r_dst       <= '0;
            r_imm       <= '0;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_alu_sel   <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // Operands captured here, so dst == src needs no hazard handling
                        r_op      <= bus.cmd_op;
                        r_dst     <= bus.cmd_dst;
                        r_imm     <= bus.cmd_imm;
                        r_alu_x   <= w_rd_a;
                        r_alu_y   <= w_rd_b;
                        r_alu_sel <= (bus.cmd_op <= OP_NOT) ? bus.cmd_op : 4'h0;
                    end
                end
                EXEC: begin
                    r_carry     <= w_new_carry;
                    r_zero      <= w_new_zero;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= (w_alu_op || w_load) ? w_result : '0;
                    r_rsp_carry <= w_new_carry;
                    r_rsp_zero  <= w_new_zero;
                    r_rsp_err   <= !(w_alu_op || w_load);
                end
                RESP: begin
                    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.alu_x      = r_alu_x;
    assign bus.alu_y      = r_alu_y;
    assign bus.alu_select = r_alu_sel;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer; the bench also plays the external 4-bit ALU.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [3:0] data;
        logic       carry;
        logic       zero;
        logic       err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stand-in for the external combinational ALU; carry is the 5th sum bit (no-borrow on subtract)
    function automatic logic [4:0] alu_ref(input logic [3:0] x, input logic [3:0] y, input logic [3:0] sel);
        logic [4:0] ny;
        ny = {1'b0, ~y};
        case (sel)
            4'h0:    return {1'b0, x};
            4'h1:    return {1'b0, x} + 5'd1;
            4'h2:    return {1'b0, x} + {1'b0, y};
            4'h3:    return {1'b0, x} + {1'b0, y} + 5'd1;
            4'h4:    return {1'b0, x} + ny;
            4'h5:    return {1'b0, x} + ny + 5'd1;
            4'h6:    return {1'b0, x} + 5'h0F;
            4'h7:    return {1'b1, x};
            4'h8:    return {1'b0, x & y};
            4'h9:    return {1'b0, x | y};
            4'hA:    return {1'b0, x ^ y};
            4'hB:    return {1'b0, ~x};
            default: return 5'd0;
        endcase
    endfunction

    assign {bus.alu_c_out, bus.alu_out} = alu_ref(bus.alu_x, bus.alu_y, bus.alu_select);

    logic [3:0] m_reg [4];
    logic       m_carry;
    logic       m_zero;
    rsp_t       sb_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
        m_carry = 1'b0;
        m_zero  = 1'b0;
        sb_q.delete();
    endtask

    task automatic dbg_chk(input logic [1:0] addr);
        bus.dbg_addr = addr;
        #1;
        chk($sformatf("dbg_r%0d", addr), bus.dbg_data, m_reg[addr]);
    endtask

    // Called on a negedge. hold>0 leaves the response un-acknowledged on return.
    task automatic do_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] a,
                          input logic [1:0] b, input logic [3:0] imm, input int hold,
                          input int exp_wait, output rsp_t e_out);
        rsp_t       e;
        rsp_t       g;
        logic [4:0] ar;
        logic [3:0] ex;
        logic [3:0] ey;
        logic [3:0] esel;
        int         waited;

        ex   = m_reg[a];
        ey   = m_reg[b];
        esel = (op <= 4'hB) ? op : 4'h0;
        e    = '0;
        if (op <= 4'hB) begin
            ar       = alu_ref(ex, ey, op);
            m_reg[dst] = ar[3:0];
            m_zero   = (ar[3:0] == 4'h0);
            if (!op[3]) m_carry = ar[4];
            e.data   = ar[3:0];
        end else if (op == OP_LOAD) begin
            m_reg[dst] = imm;
            m_zero   = (imm == 4'h0);
            e.data   = imm;
        end else begin
            e.err    = 1'b1;
        end
        e.carry = m_carry;
        e.zero  = m_zero;
        sb_q.push_back(e);
        e_out = e;

        bus.rsp_ready = (hold == 0);
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src_a = a;
        bus.cmd_src_b = b;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;

        waited = 0;
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_ready", bus.cmd_ready, 1);
        if (exp_wait >= 0) chk("accept_wait", waited, exp_wait);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end

        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("alu_x", bus.alu_x, ex);
        chk("alu_y", bus.alu_y, ey);
        chk("alu_select", bus.alu_select, esel);
        chk("exec_not_ready", bus.cmd_ready, 0);

        // rsp_valid must be seen high after exactly one further edge past the accept edge
        waited = 0;
        @(negedge clk);
        while (!bus.rsp_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("rsp_latency", waited, 1);

        g = {bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.rsp_err};
        e = sb_q.pop_front();
        chk("rsp_data", g.data, e.data);
        chk("rsp_carry", g.carry, e.carry);
        chk("rsp_zero", g.zero, e.zero);
        chk("rsp_err", g.err, e.err);
        $display("cmd op=%h dst=%0d a=%0d b=%0d imm=%h -> data=%h c=%b z=%b err=%b",
                 op, dst, a, b, imm, g.data, g.carry, g.zero, g.err);

        if (hold == 0) begin
            @(negedge clk);
            chk("rsp_cleared", bus.rsp_valid, 0);
        end
    endtask

    rsp_t       e_last;
    logic [3:0] r_op;

    initial begin
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_dst   = 2'd0;
        bus.cmd_src_a = 2'd0;
        bus.cmd_src_b = 2'd0;
        bus.cmd_imm   = 4'h0;
        bus.rsp_ready = 1'b1;
        bus.dbg_addr  = 2'd0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_fields", {bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 0);
        chk("rst_alu_drive", {bus.alu_x, bus.alu_y, bus.alu_select}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 4; i++) dbg_chk(2'(i));

        // Abort a command mid-EXEC with reset
        do_cmd(OP_LOAD, 2'd3, 2'd0, 2'd0, 4'hA, 0, 0, e_last);
        dbg_chk(2'd3);
        bus.cmd_op = OP_LOAD; bus.cmd_dst = 2'd1; bus.cmd_imm = 4'h5; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        for (int i = 0; i < 4; i++) dbg_chk(2'(i));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", bus.rsp_valid, 0);
        end
        chk("abort_cmd_ready", bus.cmd_ready, 1);

        do_cmd(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'h9, 0, 0, e_last);
        do_cmd(OP_LOAD, 2'd1, 2'd0, 2'd0, 4'h7, 0, 0, e_last);
        do_cmd(OP_ADD,  2'd2, 2'd0, 2'd1, 4'h0, 0, 0, e_last);
        dbg_chk(2'd2);
        do_cmd(OP_SUB,  2'd3, 2'd0, 2'd1, 4'h0, 0, 0, e_last);
        dbg_chk(2'd3);
        do_cmd(OP_AND,  2'd3, 2'd0, 2'd1, 4'h0, 0, 0, e_last);
        do_cmd(4'hE,    2'd0, 2'd0, 2'd1, 4'h3, 0, 0, e_last);
        dbg_chk(2'd0);

        // Back-pressure: response held while a new command waits
        do_cmd(OP_XOR, 2'd1, 2'd0, 2'd1, 4'h0, 5, 0, e_last);
        bus.cmd_op = OP_OR; bus.cmd_dst = 2'd2; bus.cmd_src_a = 2'd0; bus.cmd_src_b = 2'd1;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_fields", {bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, e_last);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_released", bus.rsp_valid, 0);
        do_cmd(OP_OR, 2'd2, 2'd0, 2'd1, 4'h0, 0, 0, e_last);

        do_cmd(OP_ADD, 2'd1, 2'd1, 2'd1, 4'h0, 0, 0, e_last);
        dbg_chk(2'd1);

        for (int n = 0; n < 40; n++) begin
            r_op = 4'($urandom_range(0, 15));
            do_cmd(r_op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0, 0, e_last);
            dbg_chk(2'($urandom_range(0, 3)));
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
